// File: rtl/s_map_pkg.sv
// Shared s_map definitions: fixed field width, per-record word count and FSM state type.
package s_map_pkg;

  localparam int S_MAP_FIXED_BITS = 3;

  // op, yp and data plus the NUM-bit adata field, rounded up to whole DW-bit words
  function automatic int s_map_words(input int num, input int dw);
    return (num + S_MAP_FIXED_BITS + dw - 1) / dw;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } s_map_state_e;

endpackage

// File: rtl/s_map_stream_tx.sv
// s_map record serializer: one record in, WORDS DW-bit words out on a valid/ready/last stream, LSB word first.
// Optional parity trailer word: define S_MAP_STREAM_TX_PARITY_EN.
module s_map_stream_tx
  import s_map_pkg::*;
#(
  parameter  int NUM   = 8,
  parameter  int DW    = 4,
  localparam int RW    = NUM + S_MAP_FIXED_BITS,
  localparam int WORDS = s_map_words(NUM, DW),
  localparam int IDX_W = $clog2(WORDS + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic             rec_op,
  input  logic             rec_yp,
  input  logic [NUM-1:0]   rec_adata,
  input  logic             rec_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx
);

  // Field order is shared with the receiver; data lands in bit 0.
  typedef struct packed {
    logic           op;
    logic           yp;
    logic [NUM-1:0] adata;
    logic           data;
  } s_map_t;

`ifdef S_MAP_STREAM_TX_PARITY_EN
  localparam int WORDS_TX = WORDS + 1;
`else
  localparam int WORDS_TX = WORDS;
`endif
  localparam int TXW = WORDS_TX * DW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_TX - 1);

  // Zero-extended record, with the parity trailer word appended when enabled.
  function automatic logic [TXW-1:0] pack_tx(input s_map_t r);
    logic [TXW-1:0] v;
    v         = '0;
    v[RW-1:0] = r;
`ifdef S_MAP_STREAM_TX_PARITY_EN
    v[WORDS*DW] = ^r;
`endif
    return v;
  endfunction

  s_map_state_e     state_q, state_d;
  logic [TXW-1:0]   sreg_q, sreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  s_map_t           rec_in;
  logic             word_hs;
  logic             load;

  assign rec_in    = {rec_op, rec_yp, rec_adata, rec_data};
  assign out_valid = (state_q == SEND);
  assign out_data  = sreg_q[DW-1:0];
  assign out_idx   = idx_q;
  assign out_last  = out_valid & (idx_q == LAST_IDX);
  assign word_hs   = out_valid & out_ready;
  // Accepting during the last-word handshake gives zero-bubble record chaining.
  assign rec_ready = (state_q == IDLE) | (word_hs & out_last);
  assign load      = rec_valid & rec_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    if (load) begin
      state_d = SEND;
      sreg_d  = pack_tx(rec_in);
      idx_d   = '0;
    end else if (word_hs) begin
      if (out_last) begin
        state_d = IDLE;
        sreg_d  = '0;
        idx_d   = '0;
      end else begin
        sreg_d = sreg_q >> DW;
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule
